// File: rtl/xpb_pkg.sv
// Shared types and helpers for the runtime-loadable xpb table generator.
package xpb_pkg;

  localparam int unsigned XPB_DATA_W = 1024;
  localparam int unsigned XPB_IDX_W  = 5;
  localparam int unsigned XPB_LIMB_W = 256;
  localparam int unsigned DEPTH      = 32'd1 << XPB_IDX_W;
  localparam int unsigned NL         = XPB_DATA_W / XPB_LIMB_W;

  typedef enum logic [1:0] {IDLE, GEN, READY} xpb_state_t;

  function automatic int unsigned depth_of(input int unsigned idx_w);
    return 32'd1 << idx_w;
  endfunction

  function automatic int unsigned nl_of(input int unsigned data_w, input int unsigned limb_w);
    return data_w / limb_w;
  endfunction

  // Bit offset of channel ch inside a packed per-channel bus.
  function automatic int unsigned index_slice(input int unsigned ch, input int unsigned width);
    return ch * width;
  endfunction

endpackage

// File: rtl/xpb_acc_step.sv
// One table-generation step: sum = acc_in + b_in (carry-out dropped).
// XPB_CARRY_SPLIT_EN selects a limb-serial adder with a registered inter-limb carry.
module xpb_acc_step
  import xpb_pkg::*;
#(
  parameter int unsigned DATA_W = XPB_DATA_W,
  parameter int unsigned LIMB_W = XPB_LIMB_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [DATA_W-1:0] acc_in,
  input  logic [DATA_W-1:0] b_in,
  output logic [DATA_W-1:0] sum,
  output logic              done
);

  // The first cycle of a run is an operand-settle slot; steps follow back to back.
  logic primed;

`ifdef XPB_CARRY_SPLIT_EN
  localparam int unsigned LIMBS = nl_of(DATA_W, LIMB_W);
  localparam int unsigned LW    = (LIMBS > 1) ? $clog2(LIMBS) : 1;

  logic [LW-1:0]     limb;
  logic              carry;
  logic [DATA_W-1:0] part;
  logic [LIMB_W:0]   limb_sum;
  logic              last_limb;

  assign last_limb = (limb == LW'(LIMBS - 1));

  always_comb begin
    limb_sum = {1'b0, acc_in[limb*LIMB_W +: LIMB_W]}
             + {1'b0, b_in[limb*LIMB_W +: LIMB_W]}
             + {{LIMB_W{1'b0}}, carry};
    sum = part;
    sum[(LIMBS-1)*LIMB_W +: LIMB_W] = limb_sum[LIMB_W-1:0];
    done = start && primed && last_limb;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      primed <= 1'b0;
      limb   <= '0;
      carry  <= 1'b0;
      part   <= '0;
    end else if (abort || !start) begin
      primed <= 1'b0;
      limb   <= '0;
      carry  <= 1'b0;
    end else if (!primed) begin
      primed <= 1'b1;
    end else begin
      part[limb*LIMB_W +: LIMB_W] <= limb_sum[LIMB_W-1:0];
      if (last_limb) begin
        limb  <= '0;
        carry <= 1'b0;
      end else begin
        limb  <= limb + 1'b1;
        carry <= limb_sum[LIMB_W];
      end
    end
  end
`else
  assign sum  = acc_in + b_in;
  assign done = start && primed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      primed <= 1'b0;
    else
      primed <= start && !abort;
  end
`endif

endmodule

// File: rtl/xpb_table_gen.sv
// Generates entry[k] = k*B into a register table, then serves NUM_CH lookups.
// Build option: XPB_CARRY_SPLIT_EN (limb-serial step adder, NL cycles per step).
module xpb_table_gen
  import xpb_pkg::*;
#(
  parameter int unsigned DATA_W = XPB_DATA_W,
  parameter int unsigned IDX_W  = XPB_IDX_W,
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned LIMB_W = XPB_LIMB_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_W-1:0]        base_in,
  input  logic                     base_load,
  output logic                     busy,
  output logic                     ready,
  input  logic                     lookup_valid_in,
  input  logic [NUM_CH*IDX_W-1:0]  idx_in,
  output logic [NUM_CH*DATA_W-1:0] data_out,
  output logic                     data_valid_out
);

  localparam int unsigned TBL_DEPTH = depth_of(IDX_W);

  xpb_state_t        state;
  logic [DATA_W-1:0] b_r;
  logic [DATA_W-1:0] acc;
  logic [IDX_W-1:0]  k;
  logic [DATA_W-1:0] tbl [TBL_DEPTH];
  logic [DATA_W-1:0] step_sum;
  logic              step_done;

  xpb_acc_step #(
    .DATA_W (DATA_W),
    .LIMB_W (LIMB_W)
  ) u_step (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (state == GEN),
    .abort  (base_load),
    .acc_in (acc),
    .b_in   (b_r),
    .sum    (step_sum),
    .done   (step_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      b_r   <= '0;
      acc   <= '0;
      k     <= '0;
      busy  <= 1'b0;
      ready <= 1'b0;
    end else if (base_load) begin
      state <= GEN;
      b_r   <= base_in;
      acc   <= '0;
      k     <= IDX_W'(1);
      busy  <= 1'b1;
      ready <= 1'b0;
    end else if (state == GEN && step_done) begin
      acc <= step_sum;
      if (k == IDX_W'(TBL_DEPTH - 1)) begin
        state <= READY;
        k     <= '0;
        busy  <= 1'b0;
        ready <= 1'b1;
      end else begin
        k <= k + 1'b1;
      end
    end
  end

  // Table contents need no reset; ready gates every read.
  always_ff @(posedge clk) begin
    if (base_load)
      tbl[0] <= '0;
    else if (state == GEN && step_done)
      tbl[k] <= step_sum;
  end

  // Reads use the pre-edge table, so a same-edge reload still returns old data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out       <= '0;
      data_valid_out <= 1'b0;
    end else if (lookup_valid_in && ready) begin
      for (int unsigned c = 0; c < NUM_CH; c++)
        data_out[c*DATA_W +: DATA_W] <= tbl[idx_in[index_slice(c, IDX_W) +: IDX_W]];
      data_valid_out <= 1'b1;
    end else begin
      data_valid_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_xpb_table_gen.sv
// Directed + randomized bench for xpb_table_gen against an arithmetic k*B reference.
module tb_xpb_table_gen;

  localparam int unsigned DW  = 1024;
  localparam int unsigned IW  = 5;
  localparam int unsigned NC  = 4;
  localparam int unsigned LWD = 256;
`ifdef XPB_CARRY_SPLIT_EN
  localparam int unsigned S = DW / LWD;
`else
  localparam int unsigned S = 1;
`endif
  localparam int unsigned GEN_CYC = 1 + ((1 << IW) - 1) * S;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [DW-1:0]    base_in = '0;
  logic             base_load = 1'b0;
  logic             busy, ready;
  logic             lookup_valid_in = 1'b0;
  logic [NC*IW-1:0] idx_in = '0;
  logic [NC*DW-1:0] data_out;
  logic             data_valid_out;

  int            total = 0;
  int            bad = 0;
  logic [DW-1:0] cur_base = '0;
  logic [DW-1:0] tmp;

  always #5 clk = ~clk;

  xpb_table_gen #(
    .DATA_W (DW),
    .IDX_W  (IW),
    .NUM_CH (NC),
    .LIMB_W (LWD)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .base_in         (base_in),
    .base_load       (base_load),
    .busy            (busy),
    .ready           (ready),
    .lookup_valid_in (lookup_valid_in),
    .idx_in          (idx_in),
    .data_out        (data_out),
    .data_valid_out  (data_valid_out)
  );

  function automatic logic [DW-1:0] ref_entry(input logic [DW-1:0] b, input int unsigned k);
    return b * DW'(k);
  endfunction

  function automatic logic [NC*IW-1:0] pack4(input int unsigned a, input int unsigned b,
                                             input int unsigned c, input int unsigned d);
    return {IW'(d), IW'(c), IW'(b), IW'(a)};
  endfunction

  function automatic logic [DW-1:0] rand_base();
    logic [DW-1:0] v;
    for (int i = 0; i < int'(DW / 32); i++) v[i*32 +: 32] = $urandom;
    v[DW-1 -: IW] = '0;
    return v;
  endfunction

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%h..%h exp=%h..%h", tag, obs[DW-1 -: 64], obs[127:0],
             exp[DW-1 -: 64], exp[127:0]);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [DW-1:0] b);
    base_in   = b;
    base_load = 1'b1;
    tick();
    base_load = 1'b0;
    cur_base  = b;
  endtask

  task automatic wait_ready(input string tag, input int start_cnt);
    int cnt;
    cnt = start_cnt;
    while (!ready && cnt < 3000) begin
      tick();
      cnt++;
    end
    check(tag, DW'(cnt), DW'(GEN_CYC));
  endtask

  task automatic do_lookup(input string tag, input logic [NC*IW-1:0] ix);
    idx_in          = ix;
    lookup_valid_in = 1'b1;
    tick();
    lookup_valid_in = 1'b0;
    check({tag, "_dv"}, DW'(data_valid_out), DW'(1));
    for (int c = 0; c < int'(NC); c++)
      check($sformatf("%s_ch%0d", tag, c), data_out[c*DW +: DW],
            ref_entry(cur_base, int'(ix[c*IW +: IW])));
    tick();
    check({tag, "_dv_drop"}, DW'(data_valid_out), DW'(0));
  endtask

  initial begin
    tick(2);
    check("rst_busy", DW'(busy), DW'(0));
    check("rst_ready", DW'(ready), DW'(0));
    check("rst_dv", DW'(data_valid_out), DW'(0));
    check("rst_data", data_out[DW-1:0], '0);
    rst_n = 1'b1;
    tick();

    // Lookup while idle is ignored
    idx_in = pack4(1, 2, 3, 4);
    lookup_valid_in = 1'b1;
    tick();
    check("idle_dv", DW'(data_valid_out), DW'(0));
    lookup_valid_in = 1'b0;

    // base=1; lookups attempted during generation are ignored
    load(DW'(1));
    check("gen_busy", DW'(busy), DW'(1));
    check("gen_ready", DW'(ready), DW'(0));
    lookup_valid_in = 1'b1;
    idx_in = pack4(0, 5, 17, 31);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("gen_dv", DW'(data_valid_out), DW'(0));
      check("gen_data", data_out[DW-1:0], '0);
    end
    lookup_valid_in = 1'b0;
    wait_ready("lat_base1", 3);
    check("ready_busy", DW'(busy), DW'(0));
    do_lookup("b1", pack4(0, 5, 17, 31));

    // Wide xpb-style constant
    tmp = rand_base();
    tmp[15:0] = 16'hb06a;
    load(tmp);
    wait_ready("lat_xpb", 0);
    do_lookup("xpb", pack4(16, 31, 1, 16));
    check("xpb_shift4", data_out[DW-1:0], tmp << 4);

    // Randomized bases and indices, including duplicates
    for (int r = 0; r < 3; r++) begin
      load(rand_base());
      wait_ready("lat_rand", 0);
      do_lookup("rnd_a", pack4($urandom_range(31), $urandom_range(31),
                               $urandom_range(31), $urandom_range(31)));
      do_lookup("rnd_dup", pack4(9, 9, $urandom_range(31), 9));
    end

    // Limb carry propagation
    tmp = '0;
    tmp[255:0] = '1;
    load(tmp);
    wait_ready("lat_carry", 0);
    do_lookup("carry", pack4(2, 31, 1, 3));

    // Truncation: carry-out of the adder is dropped
    tmp = '0;
    tmp[DW-1] = 1'b1;
    load(tmp);
    wait_ready("lat_trunc", 0);
    do_lookup("trunc", pack4(2, 1, 3, 0));
    check("trunc_idx2_zero", data_out[DW-1:0], '0);

    // Restart mid-generation
    load(DW'(1));
    tick(9);
    check("restart_pre_busy", DW'(busy), DW'(1));
    load(DW'(2));
    wait_ready("lat_restart", 0);
    do_lookup("restart", pack4(7, 31, 0, 7));
    check("restart_idx7", data_out[DW-1:0], DW'(14));

    // Reload in READY with a same-edge lookup: old table answers
    idx_in          = pack4(7, 3, 31, 1);
    lookup_valid_in = 1'b1;
    base_in         = DW'(5);
    base_load       = 1'b1;
    tick();
    base_load       = 1'b0;
    lookup_valid_in = 1'b0;
    check("reload_dv", DW'(data_valid_out), DW'(1));
    check("reload_old_ch0", data_out[DW-1:0], DW'(14));
    check("reload_old_ch2", data_out[2*DW +: DW], DW'(62));
    check("reload_ready", DW'(ready), DW'(0));
    check("reload_busy", DW'(busy), DW'(1));
    cur_base = DW'(5);
    wait_ready("lat_reload", 0);
    do_lookup("reload_new", pack4(7, 0, 31, 2));

    // Asynchronous reset mid-generation
    load(rand_base());
    tick(5);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", DW'(busy), DW'(0));
    check("arst_ready", DW'(ready), DW'(0));
    check("arst_dv", DW'(data_valid_out), DW'(0));
    check("arst_data", data_out[DW-1:0], '0);
    tick();
    rst_n = 1'b1;
    tick(3);
    check("post_rst_busy", DW'(busy), DW'(0));
    check("post_rst_ready", DW'(ready), DW'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
